// File: rtl/ip_one_port_ram.sv
// Self-running 32x8 single-port RAM exerciser: a 64-cycle sequencer writes
// address-valued data to every word, then reads all 32 words back.
module ip_one_port_ram (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    output logic [7:0] ram_wr_data,
    output logic [7:0] ram_rd_data,
    output logic [4:0] ram_addr,
    output logic       ram_rw_en
);

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

    logic [5:0]        cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Stage 0: free-running sequencer; the lower half of the count is the write phase
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= 6'd0;
        end else begin
            cnt <= cnt + 6'd1;
        end
    end

    // Stage 1: registered memory-side control, address and write data
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ram_rw_en   <= 1'b0;
            ram_addr    <= 5'd0;
            ram_wr_data <= 8'h00;
        end else begin
            ram_rw_en   <= ~cnt[5];
            ram_addr    <= cnt[4:0];
            ram_wr_data <= cnt[5] ? 8'h00 : {3'b000, cnt[4:0]};
        end
    end

    // Stage 2: memory array has no reset so it maps onto plain RAM; retained across reset
    always_ff @(posedge sys_clk) begin
        if (ram_rw_en) begin
            mem[ram_addr] <= ram_wr_data;
        end
    end

    // Read-first: a write cycle returns the word's previous contents
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ram_rd_data <= 8'h00;
        end else begin
            ram_rd_data <= mem[ram_addr];
        end
    end

endmodule

// File: tb/tb_ip_one_port_ram.sv
// Directed bench for ip_one_port_ram: reset hold, two full sequences,
// read-first behaviour and an asynchronous reset in the middle of a read pass.
module tb_ip_one_port_ram;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_data;
    logic [4:0] ram_addr;
    logic       ram_rw_en;

    int n_cmp = 0;
    int n_err = 0;
    int n = 0;          // index of the last active edge since reset release (En)
    bit mem_init = 1'b0; // set once every word holds its pattern

    ip_one_port_ram dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data),
        .ram_addr    (ram_addr),
        .ram_rw_en   (ram_rw_en)
    );

    always #10 sys_clk = ~sys_clk;   // 50 MHz

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " rw_en"},   {31'd0, ram_rw_en}, 32'd0);
        check_val({tag, " addr"},    {27'd0, ram_addr},  32'd0);
        check_val({tag, " wr_data"}, {24'd0, ram_wr_data}, 32'd0);
        check_val({tag, " rd_data"}, {24'd0, ram_rd_data}, 32'd0);
    endtask

    // Advance one clock and check outputs after edge En against the sequence table.
    task automatic step_check();
        int m;
        int mp;
        logic [31:0] exp_rw;
        logic [31:0] exp_addr;
        logic [31:0] exp_wr;
        logic [31:0] exp_rd;
        @(posedge sys_clk);
        n++;
        @(negedge sys_clk);
        m        = (n - 1) % 64;
        exp_rw   = (m < 32) ? 32'd1 : 32'd0;
        exp_addr = 32'(m % 32);
        exp_wr   = (m < 32) ? 32'(m) : 32'd0;
        check_val($sformatf("rw_en E%0d", n),   {31'd0, ram_rw_en},   exp_rw);
        check_val($sformatf("addr E%0d", n),    {27'd0, ram_addr},    exp_addr);
        check_val($sformatf("wr_data E%0d", n), {24'd0, ram_wr_data}, exp_wr);
        if (mem_init) begin
            if (n == 1) begin
                exp_rd = 32'd0;            // reset address 0 holds 0x00
            end else begin
                mp     = (n - 2) % 64;
                exp_rd = 32'(mp % 32);     // word a always holds a once written
            end
            check_val($sformatf("rd_data E%0d", n), {24'd0, ram_rd_data}, exp_rd);
        end
        if (n == 33) mem_init = 1'b1;      // address 31 committed at E33
    endtask

    initial begin
        #2 sys_rst_n = 1'b0;

        // Reset hold for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check_all_zero($sformatf("reset_hold c%0d", i));
        end

        // Release between edges; E1 is the next rising edge
        sys_rst_n = 1'b1;
        n = 0;

        // Two full periods plus start of a third: write, read, wrap, read-first, read
        while (n < 130) step_check();

        // Advance until the counter sits at 40 (mid read pass)
        while ((n % 64) != 40) step_check();

        // Asynchronous reset between edges: outputs clear without a clock
        #3 sys_rst_n = 1'b0;
        #1 check_all_zero("async_reset_now");
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check_all_zero($sformatf("async_reset_hold c%0d", i));
        end

        // Restart from the write phase; memory kept its contents
        sys_rst_n = 1'b1;
        n = 0;
        while (n < 70) step_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
